// File: rtl/montgomery_stream_io.sv
// rtl/montgomery_stream_io.sv - word-serial operand loader and result streamer for the Montgomery multiplier
module montgomery_stream_io #(
  parameter int WIDTH = 1024,
  parameter int WORD  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WORD-1:0]  s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WORD-1:0]  m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] mont_a,
  output logic [WIDTH-1:0] mont_b,
  output logic [WIDTH-1:0] mont_m,
  output logic             mont_start,
  input  logic [WIDTH-1:0] mont_result,
  input  logic             mont_done,
  output logic             busy
);

  localparam int N_WORDS = WIDTH / WORD;
  localparam int CW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [2:0] ST_LOAD_A = 3'd0;
  localparam logic [2:0] ST_LOAD_B = 3'd1;
  localparam logic [2:0] ST_LOAD_M = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_SEND   = 3'd5;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic             wait_first;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] out_reg;

  logic in_load;
  logic last_word;
  logic s_fire;
  logic m_fire;

  assign in_load   = (state == ST_LOAD_A) || (state == ST_LOAD_B) || (state == ST_LOAD_M);
  assign last_word = (cnt == CW'(N_WORDS - 1));

  // Handshake outputs are forced low while reset is asserted, not just after it.
  assign s_ready    = in_load && !reset;
  assign m_valid    = (state == ST_SEND) && !reset;
  assign mont_start = (state == ST_START) && !reset;
  assign busy       = !reset && !((state == ST_LOAD_A) && (cnt == '0));
  assign m_data     = out_reg[WORD-1:0];

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  assign mont_a = a_reg;
  assign mont_b = b_reg;
  assign mont_m = m_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LOAD_A;
      cnt        <= '0;
      wait_first <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      m_reg      <= '0;
      out_reg    <= '0;
    end else begin
      case (state)
        ST_LOAD_A, ST_LOAD_B, ST_LOAD_M: begin
          if (s_fire) begin
            // Least-significant word arrives first, so new words enter at the top.
            case (state)
              ST_LOAD_A: a_reg <= {s_data, a_reg[WIDTH-1:WORD]};
              ST_LOAD_B: b_reg <= {s_data, b_reg[WIDTH-1:WORD]};
              default:   m_reg <= {s_data, m_reg[WIDTH-1:WORD]};
            endcase
            if (last_word) begin
              cnt <= '0;
              case (state)
                ST_LOAD_A: state <= ST_LOAD_B;
                ST_LOAD_B: state <= ST_LOAD_M;
                default:   state <= ST_START;
              endcase
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_START: begin
          state      <= ST_WAIT;
          wait_first <= 1'b1;
        end

        ST_WAIT: begin
          // A done level left over from the previous operation is skipped.
          wait_first <= 1'b0;
          if (!wait_first && mont_done) begin
            out_reg <= mont_result;
            state   <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (m_fire) begin
            out_reg <= {{WORD{1'b0}}, out_reg[WIDTH-1:WORD]};
            if (last_word) begin
              cnt   <= '0;
              state <= ST_LOAD_A;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_LOAD_A;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_stream_io.sv
// tb/tb_montgomery_stream_io.sv - directed bench with a stub multiplier and an output word model
module tb_montgomery_stream_io;

  localparam int WIDTH = 1024;
  localparam int WORD  = 32;
  localparam int NW    = WIDTH / WORD;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WORD-1:0]  s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WORD-1:0]  m_data;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [WIDTH-1:0] mont_a;
  logic [WIDTH-1:0] mont_b;
  logic [WIDTH-1:0] mont_m;
  logic             mont_start;
  logic [WIDTH-1:0] mont_result;
  logic             mont_done;
  logic             busy;

  montgomery_stream_io #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_start(mont_start), .mont_result(mont_result), .mont_done(mont_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_w(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Stub multiplier: mode 0 pulses done 10 cycles after start; mode 1 keeps a
  // stale done high through the first WAIT cycle, then low 20 cycles, then high.
  int               stub_mode = 0;
  logic             stub_clr = 1'b0;
  logic             started = 1'b0;
  int               since = 0;
  logic             got_valid = 1'b0;
  logic [WIDTH-1:0] res = '0;

  always @(posedge clk) begin
    if (stub_clr) begin
      started   <= 1'b0;
      since     <= 0;
      got_valid <= 1'b0;
    end else begin
      if (mont_start) begin
        started <= 1'b1;
        since   <= 1;
        res     <= mont_a ^ mont_b ^ mont_m;
      end else if (started) begin
        since <= since + 1;
      end
      if (m_valid) got_valid <= 1'b1;
    end
  end

  assign mont_done = (stub_mode == 0) ? (started && since == 10)
                                      : (!started || since == 1 || (since >= 22 && !got_valid));
  assign mont_result = (started && since >= ((stub_mode == 0) ? 10 : 22)) ? res : {32{32'hDEAD_BEEF}};

  // Model: expected operands and the queue of result words still owed.
  logic [31:0]      exp_q[$];
  logic [WIDTH-1:0] exp_a = '0;
  logic [WIDTH-1:0] exp_b = '0;
  logic [WIDTH-1:0] exp_m = '0;
  logic [31:0]      out_log[NW];
  int               n_xfer = 0;
  int               n_starts = 0;
  int               start_cyc = -1;
  int               first_valid_cyc = -1;
  int               last_xfer_cyc = -1;
  int               sready_rise_cyc = -1;
  logic             prev_start = 1'b0;
  logic             prev_valid = 1'b0;
  logic             prev_sready = 1'b0;

  always @(negedge clk) begin
    if (mont_start) begin
      chk_b("start_one_cycle", prev_start, 1'b0);
      chk_w("start_mont_a", mont_a, exp_a);
      chk_w("start_mont_b", mont_b, exp_b);
      chk_w("start_mont_m", mont_m, exp_m);
      n_starts++;
      start_cyc = cyc;
    end
    if (m_valid) begin
      chk_b("excl_s_ready", s_ready, 1'b0);
      chk_w("hold_mont_a", mont_a, exp_a);
      if (!prev_valid) first_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_m_valid: m_data %0h with no word due", m_data);
      end else begin
        chk_v("m_data", m_data, exp_q[0]);
        if (m_ready) begin
          if (n_xfer < NW) out_log[n_xfer] = m_data;
          n_xfer++;
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) last_xfer_cyc = cyc;
        end
      end
    end
    if (s_ready && !prev_sready) sready_rise_cyc = cyc;
    prev_start  = mont_start;
    prev_valid  = m_valid;
    prev_sready = s_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input bit gap, input bit expect_out, output int l0);
    for (int k = 0; k < NW; k++) begin
      exp_a[32*k +: 32] = k + 1;
      exp_b[32*k +: 32] = 32'h100 + k;
      exp_m[32*k +: 32] = 32'h200 + k;
      if (expect_out) exp_q.push_back((k + 1) ^ (32'h100 + k) ^ (32'h200 + k));
    end
    n_xfer   = 0;
    stub_clr = 1'b1;
    l0       = cyc;
    for (int w = 0; w < 3 * NW; w++) begin
      if (gap) begin
        s_valid = 1'b0;
        tick();
        stub_clr = 1'b0;
      end
      s_valid = 1'b1;
      if (w < NW)          s_data = w + 1;
      else if (w < 2 * NW) s_data = 32'h100 + (w - NW);
      else                 s_data = 32'h200 + (w - 2 * NW);
      tick();
      stub_clr = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(exp_q.size() == 0 && s_ready && !busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: %0d words still owed after %0d cycles", nm, exp_q.size(), n);
    end
    tick();
  endtask

  initial begin
    int l0;
    int ns;
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = '1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_b("rst_s_ready", s_ready, 1'b0);
      chk_b("rst_m_valid", m_valid, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_mont_start", mont_start, 1'b0);
      chk_v("rst_m_data", m_data, 32'h0);
      chk_w("rst_mont_a", mont_a, '0);
      @(posedge clk);
    end
    #1;
    reset   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk_b("post_rst_s_ready", s_ready, 1'b1);
    chk_b("post_rst_busy", busy, 1'b0);
    tick();

    // Golden transfer
    ns = n_starts;
    load_ops(1'b0, 1'b1, l0);
    @(negedge clk);
    #1;
    chk_v("gold_start_cycle", start_cyc, l0 + 96);
    chk_v("gold_start_count", n_starts, ns + 1);
    chk_v("gold_a_lsw", mont_a[31:0], 32'h1);
    chk_v("gold_a_msw", mont_a[1023:992], 32'h20);
    wait_idle("gold");
    chk_v("gold_first_valid", first_valid_cyc, start_cyc + 11);
    chk_v("gold_last_xfer", last_xfer_cyc, start_cyc + 42);
    chk_v("gold_s_ready_back", sready_rise_cyc, start_cyc + 43);
    chk_v("gold_xfers", n_xfer, NW);
    chk_v("gold_word0", out_log[0], 32'h301);
    chk_v("gold_word7", out_log[7], 32'h308);
    chk_v("gold_word31", out_log[31], 32'h320);

    // Input gaps
    ns = n_starts;
    load_ops(1'b1, 1'b1, l0);
    @(negedge clk);
    #1;
    chk_v("gap_start_cycle", start_cyc, l0 + 192);
    chk_v("gap_start_count", n_starts, ns + 1);
    wait_idle("gap");
    chk_v("gap_xfers", n_xfer, NW);

    // Backpressure at word 7
    load_ops(1'b0, 1'b1, l0);
    for (int n = 0; n < 100 && n_xfer < 7; n++) tick();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_v("bp_hold_word7", m_data, 32'h308);
      chk_b("bp_valid", m_valid, 1'b1);
      tick();
    end
    m_ready = 1'b1;
    wait_idle("bp");
    chk_v("bp_xfers", n_xfer, NW);

    // Stale level done
    stub_mode = 1;
    load_ops(1'b0, 1'b1, l0);
    @(negedge clk);
    #1;
    wait_idle("stale");
    chk_v("stale_first_valid", first_valid_cyc, start_cyc + 23);
    chk_v("stale_xfers", n_xfer, NW);
    stub_mode = 0;

    // Reset during WAIT
    load_ops(1'b0, 1'b0, l0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk_b("rstwait_m_valid", m_valid, 1'b0);
    chk_b("rstwait_busy", busy, 1'b0);
    chk_b("rstwait_s_ready", s_ready, 1'b1);
    chk_w("rstwait_mont_a", mont_a, '0);
    tick();

    // Fresh load after the abandoned operation
    ns = n_starts;
    load_ops(1'b0, 1'b1, l0);
    @(negedge clk);
    #1;
    chk_v("fresh_start_cycle", start_cyc, l0 + 96);
    chk_v("fresh_start_count", n_starts, ns + 1);
    wait_idle("fresh");
    chk_v("fresh_first_valid", first_valid_cyc, start_cyc + 11);
    chk_v("fresh_xfers", n_xfer, NW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d mismatched so far", n_bad);
    $fatal(1);
  end

endmodule

// File: doc/montgomery_stream_io.md
# montgomery_stream_io

Word-serial front/back end for the 1024-bit Montgomery multiplier. It accepts operands A, B and M as a stream of 32-bit words and assembles them into 1024-bit registers. It then issues a single start pulse to the multiplier and waits for its done. It captures the 1024-bit result and streams it back out as 32-bit words. It sits between the bus/DMA side and the multiplier: upstream of the multiplier's operand inputs, downstream of its result port.

## Interface
- `WIDTH`, 1024, operand/result width; must be a multiple of `WORD`.
- `WORD`, 32, stream word width; `N_WORDS = WIDTH/WORD` (32), derived.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `s_data` in WORD: input operand word.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: block accepts a word.
- `m_data` out WORD: result word.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: consumer accepts a word.
- `mont_a`, `mont_b`, `mont_m` out WIDTH: operands to multiplier.
- `mont_start` out 1: one-cycle start pulse to multiplier.
- `mont_result` in WIDTH: multiplier result.
- `mont_done` in 1: multiplier done (level or pulse).
- `busy` out 1: operation in progress.

## Operation
- States are LOAD_A, LOAD_B, LOAD_M, START, WAIT and SEND. Reset enters LOAD_A with word counter 0.
- **Load states:** `s_ready`=1.
  - A word transfers on `s_valid & s_ready`.
  - Word order is least-significant first: word k lands in bits [WORD*k+WORD-1 : WORD*k]. Implemented as a right shift with insert at the MSB end.
  - The counter increments per transfer. On the transfer with counter = N_WORDS-1, the counter clears and the state advances LOAD_A→LOAD_B→LOAD_M→START.
  - With `s_valid`=0 the state and registers hold.
- **START:** `mont_start`=1 for exactly this one cycle, then go to WAIT unconditionally.
- **WAIT:**
  - `mont_done` is ignored in the first WAIT cycle, which protects against a stale level-done from the previous operation.
  - From the second WAIT cycle on, the first cycle with `mont_done`=1 captures `mont_result` into the output shift register and moves to SEND.
- **SEND:** `m_valid`=1 and `m_data` = output register bits [WORD-1:0].
  - On `m_valid & m_ready` the register shifts right by WORD and the counter increments.
  - On the transfer with counter = N_WORDS-1, the counter clears and the state returns to LOAD_A.
  - While `m_valid & !m_ready`, `m_data` is held stable.
- **Operand hold:** `mont_a/b/m` are driven directly from the operand registers. They hold from START through the end of SEND and are overwritten only by the next load.
- **busy:** 1 in every state except LOAD_A with counter 0.
- No arithmetic is performed. The block does not check whether operands are < M.

## Timing
- **Reset values:**
  - `s_ready`=0 while `reset` is high, then 1 in the first cycle after reset.
  - `m_valid`=0, `m_data`=0, `mont_start`=0, `mont_a/b/m`=0, `busy`=0.
  - State LOAD_A, counters 0.
- Minimum load time is 3·N_WORDS = 96 cycles.
- **Start and capture latency:**
  - Last M word accepted at cycle t; `mont_start`=1 at t+1; WAIT entered at t+2.
  - `mont_done` is honoured from t+3 onward.
  - If done is seen at cycle d, `m_valid`=1 from d+1.
- **Drain:** with `m_ready` held at 1, the last result word transfers at d+32, and `s_ready`=1 again at d+33.
- **Exclusivity:** `s_ready` and `m_valid` are never both 1. `mont_start` is never high outside START.
- **Reset mid-operation:** all state is abandoned within one cycle. Any later `mont_done` is ignored because the block is in a load state. The multiplier is not reset by this block.

## Test plan
- **Reset:** hold `reset` for 3 cycles with `s_valid`=1 → `s_ready`=0 and all outputs 0 during reset; `s_ready`=1 on the first cycle after.
- **Golden transfer:**
  - Stimulus: stream A words k+1, B words 0x100+k, M words 0x200+k (k=0..31) with `s_valid` always high. A stub multiplier pulses done 10 cycles after start, with result = A^B^M.
  - Required response:
    - `mont_a[31:0]`=1 and `mont_a[1023:992]`=0x20.
    - `mont_start` high exactly one cycle, at the cycle after the 96th word.
    - Output words equal (k+1)^(0x100+k)^(0x200+k), LSW first.
- **Input gaps:** same vectors with `s_valid` toggling every cycle → identical `mont_a/b/m`; `mont_start` after 192 cycles.
- **Backpressure:** drop `m_ready` for 5 cycles at word 7 → `m_data` held at word 7, no word lost or duplicated; 32 transfers total.
- **Stale done:** stub holds `mont_done`=1 until it sees start, then clears for 20 cycles → capture occurs only on the second rise.
- **Reset in WAIT:** assert `reset` 1 cycle during WAIT, then the stub pulses done → `m_valid` stays 0, `busy`=0, and a fresh load works normally.
